// File: rtl/vga_pkg.sv
// Shared widths, screen geometry and arbiter state encodings for the VGA plot path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOR_W  = 3;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DRAW = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/rect_scanner.sv
// Column/row walker for a rectangle fill; col advances fastest, row on col wrap.
// Latency: counters move on the edge after step; last is combinational on the current indices.
// Backpressure: none; the owner only pulses step when it consumes the current pixel.
module rect_scanner #(
   parameter int X_W = vga_pkg::X_W,
   parameter int Y_W = vga_pkg::Y_W
) (
   input  logic           core_clk,
   input  logic           reset,
   input  logic           start,
   input  logic           step,
   input  logic [X_W-1:0] w,
   input  logic [Y_W-1:0] h,
   output logic [X_W-1:0] col,
   output logic [Y_W-1:0] row,
   output logic           last
);

   logic col_end;

   // col and row never exceed w-1 / h, so full-scale w and h cannot overflow the counters
   assign col_end = (col == w - X_W'(1));
   assign last    = col_end && (row == h - Y_W'(1));

   // Clear on start, otherwise advance one pixel per step
   always_ff @(posedge core_clk) begin
      if (reset || start) begin
         col <= '0;
         row <= '0;
      end else if (step) begin
         if (col_end) begin
            col <= '0;
            row <= row + Y_W'(1);
         end else begin
            col <= col + X_W'(1);
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin share of the VGA pixel-write port among NUM_REQ rectangle-fill requesters.
// Latency: req sampled in IDLE -> gnt next cycle -> first plot the cycle after; done one cycle after last plot.
// Backpressure: requesters hold req/fields until gnt; one request served at a time. Optional VGA_CLIP_EN masks off-screen pixels.
module vga_plot_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int X_W      = vga_pkg::X_W,
   parameter int Y_W      = vga_pkg::Y_W,
`ifdef VGA_CLIP_EN
   parameter int SCREEN_W = vga_pkg::SCREEN_W,
   parameter int SCREEN_H = vga_pkg::SCREEN_H,
`endif
   parameter int COLOR_W  = vga_pkg::COLOR_W
) (
   input  logic                       CLOCK_50,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*X_W-1:0]     req_x0,
   input  logic [NUM_REQ*Y_W-1:0]     req_y0,
   input  logic [NUM_REQ*X_W-1:0]     req_w,
   input  logic [NUM_REQ*Y_W-1:0]     req_h,
   input  logic [NUM_REQ*COLOR_W-1:0] req_color,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic                       busy,
   output logic [X_W-1:0]             x,
   output logic [Y_W-1:0]             y,
   output logic [COLOR_W-1:0]         colour,
   output logic                       plot
);

   import vga_pkg::*;

   localparam int SEL_W = $clog2(NUM_REQ);

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   rr, sel, pick;
   logic               found;
   logic [X_W-1:0]     x0_q, w_q;
   logic [Y_W-1:0]     y0_q, h_q;
   logic [COLOR_W-1:0] color_q;
   logic               issue, last_q;
   logic [X_W-1:0]     col;
   logic [Y_W-1:0]     row;
   logic               last;
   logic [X_W:0]       x_sum;
   logic [Y_W:0]       y_sum;

   assign busy  = (state != ST_IDLE);
   assign x_sum = {1'b0, x0_q} + {1'b0, col};
   assign y_sum = {1'b0, y0_q} + {1'b0, row};

   rect_scanner #(.X_W(X_W), .Y_W(Y_W)) u_scan (
      .core_clk (CLOCK_50),
      .reset    (reset),
      .start    (state == ST_IDLE),
      .step     (issue),
      .w        (w_q),
      .h        (h_q),
      .col      (col),
      .row      (row),
      .last     (last)
   );

   // First active request at or after the round-robin pointer
   always_comb begin
      found = 1'b0;
      pick  = rr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[(int'(rr) + k) % NUM_REQ]) begin
            found = 1'b1;
            pick  = SEL_W'((int'(rr) + k) % NUM_REQ);
         end
      end
   end

   // Next state, grant/done pulses and the per-cycle pixel issue strobe
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      gnt       = '0;
      done      = '0;
      case (state)
         ST_IDLE: if (found) state_nxt = ST_LOAD;
         ST_LOAD: begin
            gnt[sel] = 1'b1;
            if (w_q == '0 || h_q == '0) begin
               state_nxt = ST_FIN;
            end else begin
               issue     = 1'b1;
               state_nxt = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (last_q) state_nxt = ST_FIN;
            else        issue     = 1'b1;
         end
         ST_FIN: begin
            done[sel] = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register, request latch and round-robin pointer update
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state   <= ST_IDLE;
         rr      <= '0;
         sel     <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && found) begin
            sel     <= pick;
            x0_q    <= req_x0[pick*X_W +: X_W];
            y0_q    <= req_y0[pick*Y_W +: Y_W];
            w_q     <= req_w[pick*X_W +: X_W];
            h_q     <= req_h[pick*Y_W +: Y_W];
            color_q <= req_color[pick*COLOR_W +: COLOR_W];
         end
         if (state == ST_FIN) begin
            rr <= (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
         end
      end
   end

   // Registered pixel port; last_q remembers whether the pixel just issued closes the rectangle
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         plot   <= 1'b0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
         last_q <= 1'b0;
      end else begin
`ifdef VGA_CLIP_EN
         plot <= issue && (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
`else
         plot <= issue;
`endif
         if (issue) begin
            x      <= X_W'(x_sum);
            y      <= Y_W'(y_sum);
            colour <= color_q;
            last_q <= last;
         end
      end
   end

endmodule
